// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
//   DIV_W       operand width (only 32 is supported)
//   DIV_ITERS   restoring iterations per divide
//   div_state_e controller states
package div_pkg;

   localparam int DIV_W     = 32;
   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
//   r       partial remainder before the step
//   bit_in  next dividend bit shifted into the remainder
//   d       divisor magnitude
//   r_next  partial remainder after the step
//   q_bit   quotient bit produced by the step
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] r,
   input  logic         bit_in,
   input  logic [W-1:0] d,
   output logic [W-1:0] r_next,
   output logic         q_bit
);

   logic [W:0] trial;

   // r < d always holds, so the shifted remainder fits in W+1 bits and a
   // successful trial fits back into W bits.
   assign trial  = {r, bit_in} - {1'b0, d};
   assign q_bit  = ~trial[W];
   assign r_next = q_bit ? trial[W-1:0] : {r[W-2:0], bit_in};

endmodule

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring divider with independent valid/ready operand
// channels and a single-cycle result pulse.
//   clk, resetn                  clock, synchronous active-low reset
//   s_axis_dividend_*            dividend channel (tdata/tvalid/tready)
//   s_axis_divisor_*             divisor channel (tdata/tvalid/tready)
//   m_axis_dout_tdata            {quotient, remainder}, held until next result
//   m_axis_dout_tvalid           one-cycle pulse, no backpressure
//
// state    | meaning
// DIV_IDLE | collect both operands
// DIV_BUSY | 32 restoring iterations
// DIV_DONE | result valid for one cycle, then release operand slots
module iter_div
   import div_pkg::*;
#(
   parameter bit SIGNED = 1'b1,
   parameter int W      = DIV_W
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [W-1:0]   s_axis_dividend_tdata,
   input  logic           s_axis_dividend_tvalid,
   output logic           s_axis_dividend_tready,
   input  logic [W-1:0]   s_axis_divisor_tdata,
   input  logic           s_axis_divisor_tvalid,
   output logic           s_axis_divisor_tready,
   output logic [2*W-1:0] m_axis_dout_tdata,
   output logic           m_axis_dout_tvalid
);

   localparam int               CNT_W    = $clog2(DIV_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

   div_state_e state_q, state_d;

   logic             have_a, have_b;
   logic [W-1:0]     a_q, b_q;
   logic [W-1:0]     q_q, r_q, d_q;
   logic             neg_quo, neg_rem;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0]   dout_q;

   logic         acc_a, acc_b, start, last;
   logic [W-1:0] a_val, b_val, a_mag, b_mag;
   logic         a_neg, b_neg;
   logic [W-1:0] r_nxt, q_nxt, q_fix, r_fix;
   logic         q_bit;

   assign s_axis_dividend_tready = (state_q == DIV_IDLE) && !have_a;
   assign s_axis_divisor_tready  = (state_q == DIV_IDLE) && !have_b;
   assign m_axis_dout_tvalid     = (state_q == DIV_DONE);
   assign m_axis_dout_tdata      = dout_q;

   assign acc_a = s_axis_dividend_tvalid && s_axis_dividend_tready;
   assign acc_b = s_axis_divisor_tvalid && s_axis_divisor_tready;
   assign start = (state_q == DIV_IDLE) && (have_a || acc_a) && (have_b || acc_b);
   assign last  = (state_q == DIV_BUSY) && (cnt == CNT_LAST);

   // An operand arriving on the starting edge is used straight from the bus.
   assign a_val = acc_a ? s_axis_dividend_tdata : a_q;
   assign b_val = acc_b ? s_axis_divisor_tdata  : b_q;
   assign a_neg = SIGNED && a_val[W-1];
   assign b_neg = SIGNED && b_val[W-1];
   // Negating 0x80000000 wraps to itself, which is its correct unsigned magnitude.
   assign a_mag = a_neg ? -a_val : a_val;
   assign b_mag = b_neg ? -b_val : b_val;

   // q_q starts as the dividend and fills with quotient bits from the bottom.
   div_step #(.W(W)) u_step (
      .r      (r_q),
      .bit_in (q_q[W-1]),
      .d      (d_q),
      .r_next (r_nxt),
      .q_bit  (q_bit)
   );

   assign q_nxt = {q_q[W-2:0], q_bit};
   assign q_fix = neg_quo ? -q_nxt : q_nxt;
   assign r_fix = neg_rem ? -r_nxt : r_nxt;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= DIV_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: if (start) state_d = DIV_BUSY;
         DIV_BUSY: if (last)  state_d = DIV_DONE;
         DIV_DONE:            state_d = DIV_IDLE;
         default:             state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         have_a  <= 1'b0;
         have_b  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
         cnt     <= '0;
         dout_q  <= '0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (acc_a) begin
                  a_q    <= s_axis_dividend_tdata;
                  have_a <= 1'b1;
               end
               if (acc_b) begin
                  b_q    <= s_axis_divisor_tdata;
                  have_b <= 1'b1;
               end
               if (start) begin
                  q_q     <= a_mag;
                  d_q     <= b_mag;
                  r_q     <= '0;
                  cnt     <= '0;
                  neg_quo <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
               end
            end
            DIV_BUSY: begin
               r_q <= r_nxt;
               q_q <= q_nxt;
               cnt <= cnt + CNT_W'(1);
               if (last) dout_q <= {q_fix, r_fix};
            end
            DIV_DONE: begin
               have_a <= 1'b0;
               have_b <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: one unsigned and one signed instance,
// scoreboard queues filled at operand hand-off and drained on result pulses.
module tb_iter_div;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] dvd_data  [2];
   logic        dvd_valid [2];
   logic        dvd_ready [2];
   logic [31:0] dvs_data  [2];
   logic        dvs_valid [2];
   logic        dvs_ready [2];
   logic [63:0] dout_data [2];
   logic        dout_valid[2];

   logic [63:0] sb_u[$];
   logic [63:0] sb_s[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iter_div #(.SIGNED(1'b0), .W(32)) u_div_u (
      .clk                    (clk),
      .resetn                 (resetn),
      .s_axis_dividend_tdata  (dvd_data[0]),
      .s_axis_dividend_tvalid (dvd_valid[0]),
      .s_axis_dividend_tready (dvd_ready[0]),
      .s_axis_divisor_tdata   (dvs_data[0]),
      .s_axis_divisor_tvalid  (dvs_valid[0]),
      .s_axis_divisor_tready  (dvs_ready[0]),
      .m_axis_dout_tdata      (dout_data[0]),
      .m_axis_dout_tvalid     (dout_valid[0])
   );

   iter_div #(.SIGNED(1'b1), .W(32)) u_div_s (
      .clk                    (clk),
      .resetn                 (resetn),
      .s_axis_dividend_tdata  (dvd_data[1]),
      .s_axis_dividend_tvalid (dvd_valid[1]),
      .s_axis_dividend_tready (dvd_ready[1]),
      .s_axis_divisor_tdata   (dvs_data[1]),
      .s_axis_divisor_tvalid  (dvs_valid[1]),
      .s_axis_divisor_tready  (dvs_ready[1]),
      .m_axis_dout_tdata      (dout_data[1]),
      .m_axis_dout_tvalid     (dout_valid[1])
   );

   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'h0) begin
         q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int sel, input logic [31:0] a, input logic [31:0] b);
      if (sel == 1) sb_s.push_back(ref_div(1'b1, a, b));
      else          sb_u.push_back(ref_div(1'b0, a, b));
   endtask

   // gap 0: same edge; gap > 0: dividend first; gap < 0: divisor first.
   task automatic offer(input int sel, input logic [31:0] a, input logic [31:0] b, input int gap);
      int g;
      g = (gap < 0) ? -gap : gap;
      dvd_data[sel] = a;
      dvs_data[sel] = b;
      if (gap == 0) begin
         dvd_valid[sel] = 1'b1;
         dvs_valid[sel] = 1'b1;
         tick();
         dvd_valid[sel] = 1'b0;
         dvs_valid[sel] = 1'b0;
      end else begin
         if (gap > 0) dvd_valid[sel] = 1'b1;
         else         dvs_valid[sel] = 1'b1;
         tick();
         dvd_valid[sel] = 1'b0;
         dvs_valid[sel] = 1'b0;
         checks++;
         if (dvd_ready[sel] !== (gap < 0) || dvs_ready[sel] !== (gap > 0)) begin
            errors++;
            $display("FAIL partial_ready: dividend_ready=%b divisor_ready=%b, want %b/%b",
                     dvd_ready[sel], dvs_ready[sel], gap < 0, gap > 0);
         end
         repeat (g - 1) tick();
         if (gap > 0) dvs_valid[sel] = 1'b1;
         else         dvd_valid[sel] = 1'b1;
         tick();
         dvd_valid[sel] = 1'b0;
         dvs_valid[sel] = 1'b0;
      end
      push_exp(sel, a, b);
   endtask

   // Called right after the capturing edge; checks latency, hold, data and pulse width.
   task automatic collect(input int sel, input string name);
      int          n;
      logic [63:0] prev, exp;
      bit          stable;
      n      = 0;
      prev   = dout_data[sel];
      stable = 1'b1;
      while (dout_valid[sel] !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (dout_valid[sel] !== 1'b1 && dout_data[sel] !== prev) stable = 1'b0;
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, want 32", name, n);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL %s hold: tdata changed before pulse (was %h)", name, prev);
      end
      checks++;
      if ((sel == 1 ? sb_s.size() : sb_u.size()) == 0) begin
         errors++;
         $display("FAIL %s scoreboard: empty, got %h", name, dout_data[sel]);
      end else begin
         exp = (sel == 1) ? sb_s.pop_front() : sb_u.pop_front();
         if (dout_data[sel] !== exp) begin
            errors++;
            $display("FAIL %s data: got %h, want %h", name, dout_data[sel], exp);
         end
      end
      tick();
      checks++;
      if (dout_valid[sel] !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse_width: tvalid=%b, want 0", name, dout_valid[sel]);
      end
      checks++;
      if (dvd_ready[sel] !== 1'b1 || dvs_ready[sel] !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_after_done: %b/%b, want 1/1", name, dvd_ready[sel], dvs_ready[sel]);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (dvd_ready[s] !== 1'b1 || dvs_ready[s] !== 1'b1 || dout_valid[s] !== 1'b0 || dout_data[s] !== 64'h0) begin
            errors++;
            $display("FAIL reset[%0d]: readys=%b/%b tvalid=%b tdata=%h, want 1/1 0 0",
                     s, dvd_ready[s], dvs_ready[s], dout_valid[s], dout_data[s]);
         end
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_unsigned_basic();
      offer(0, 32'd100, 32'd7, 0);
      collect(0, "u_100_7");
      checks++;
      if (dout_data[0] !== {32'h0000_000E, 32'h0000_0002}) begin
         errors++;
         $display("FAIL u_100_7 const: got %h, want 0000000e00000002", dout_data[0]);
      end
   endtask

   task automatic test_signed_separate();
      offer(1, 32'hFFFF_FFF9, 32'd2, 5);
      collect(1, "s_m7_2");
      checks++;
      if (dout_data[1] !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL s_m7_2 const: got %h, want fffffffdffffffff", dout_data[1]);
      end
      offer(1, 32'd17, 32'hFFFF_FFFB, -3);
      collect(1, "s_17_m5_divisor_first");
   endtask

   task automatic test_boundaries();
      offer(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      collect(1, "s_overflow");
      offer(1, 32'hFFFF_FFF9, 32'h0, 0);
      collect(1, "s_neg_div0");
      offer(1, 32'd5, 32'h0, 0);
      collect(1, "s_pos_div0");
      offer(0, 32'd5, 32'h0, 0);
      collect(0, "u_div0");
      offer(0, 32'hFFFF_FFFF, 32'h1, 2);
      collect(0, "u_max_1");
      offer(1, 32'h8000_0000, 32'h1, 0);
      collect(1, "s_min_1");
   endtask

   task automatic test_back_to_back();
      int          n;
      bit          ready_ok;
      logic [63:0] exp;
      dvd_data[0]  = 32'd1000;
      dvs_data[0]  = 32'd33;
      dvd_valid[0] = 1'b1;
      dvs_valid[0] = 1'b1;
      push_exp(0, 32'd1000, 32'd33);
      tick();
      dvd_data[0] = 32'hDEAD_BEEF;
      dvs_data[0] = 32'd12345;
      push_exp(0, 32'hDEAD_BEEF, 32'd12345);
      n        = 0;
      ready_ok = 1'b1;
      if (dvd_ready[0] !== 1'b0 || dvs_ready[0] !== 1'b0) ready_ok = 1'b0;
      while (dout_valid[0] !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (dvd_ready[0] !== 1'b0 || dvs_ready[0] !== 1'b0) ready_ok = 1'b0;
      end
      checks++;
      if (!ready_ok) begin
         errors++;
         $display("FAIL hold_valid ready: tready rose during BUSY/DONE");
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL hold_valid latency: got %0d edges, want 32", n);
      end
      checks++;
      exp = sb_u.pop_front();
      if (dout_data[0] !== exp) begin
         errors++;
         $display("FAIL hold_valid data: got %h, want %h", dout_data[0], exp);
      end
      tick();
      checks++;
      if (dvd_ready[0] !== 1'b1 || dvs_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL hold_valid ready_k33: %b/%b, want 1/1", dvd_ready[0], dvs_ready[0]);
      end
      tick();
      dvd_valid[0] = 1'b0;
      dvs_valid[0] = 1'b0;
      collect(0, "back_to_back_second");
   endtask

   task automatic test_reset_mid();
      bit pulse;
      dvd_data[1]  = 32'd1000;
      dvs_data[1]  = 32'd3;
      dvd_valid[1] = 1'b1;
      dvs_valid[1] = 1'b1;
      tick();
      dvd_valid[1] = 1'b0;
      dvs_valid[1] = 1'b0;
      repeat (10) tick();
      resetn = 1'b0;
      tick();
      checks++;
      if (dvd_ready[1] !== 1'b1 || dvs_ready[1] !== 1'b1 || dout_valid[1] !== 1'b0 || dout_data[1] !== 64'h0) begin
         errors++;
         $display("FAIL reset_mid: readys=%b/%b tvalid=%b tdata=%h, want 1/1 0 0",
                  dvd_ready[1], dvs_ready[1], dout_valid[1], dout_data[1]);
      end
      resetn = 1'b1;
      pulse  = 1'b0;
      repeat (40) begin
         tick();
         if (dout_valid[1] !== 1'b0) pulse = 1'b1;
      end
      checks++;
      if (pulse) begin
         errors++;
         $display("FAIL reset_mid pulse: tvalid seen after reset, want none");
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [63:0] prev [2];
      logic [63:0] exp;
      bit          stable;
      int          n;
      for (int i = 0; i < 1000; i++) begin
         for (int s = 0; s < 2; s++) begin
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
               0: b = 32'h0;
               1: b = $urandom_range(1, 15);
               2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
               3: b = -$urandom_range(1, 15);
               default: ;
            endcase
            dvd_data[s]  = a;
            dvs_data[s]  = b;
            dvd_valid[s] = 1'b1;
            dvs_valid[s] = 1'b1;
            push_exp(s, a, b);
            prev[s] = dout_data[s];
         end
         tick();
         for (int s = 0; s < 2; s++) begin
            dvd_valid[s] = 1'b0;
            dvs_valid[s] = 1'b0;
         end
         n      = 0;
         stable = 1'b1;
         while (dout_valid[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
            for (int s = 0; s < 2; s++)
               if (dout_valid[s] !== 1'b1 && dout_data[s] !== prev[s]) stable = 1'b0;
         end
         checks++;
         if (!stable || n != 32 || dout_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL rand[%0d] timing: edges=%0d stable=%b s_valid=%b", i, n, stable, dout_valid[1]);
         end
         for (int s = 0; s < 2; s++) begin
            exp = (s == 1) ? sb_s.pop_front() : sb_u.pop_front();
            checks++;
            if (dout_data[s] !== exp) begin
               errors++;
               $display("FAIL rand[%0d] data[%0d]: a=%h b=%h got %h, want %h",
                        i, s, dvd_data[s], dvs_data[s], dout_data[s], exp);
            end
         end
         tick();
      end
   endtask

   initial begin
      resetn = 1'b0;
      for (int s = 0; s < 2; s++) begin
         dvd_data[s]  = '0;
         dvs_data[s]  = '0;
         dvd_valid[s] = 1'b0;
         dvs_valid[s] = 1'b0;
      end
      test_reset();
      test_unsigned_basic();
      test_signed_separate();
      test_boundaries();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
